// File: rtl/dqs_delay_trainer.sv
// Single-lane DQS delay-line trainer: sweeps taps upward from tap 0 to find the
// passing eye window, then walks back down to the window centre.
module dqs_delay_trainer #(
  parameter int TAP_MAX       = 127,
  parameter int SETTLE_CYCLES = 8,
  parameter int SAMPLE_CYCLES = 16
) (
  input  logic       FAB_CLK,
  input  logic       SYNC_RST,
  input  logic       START,
  input  logic       EYE_MONITOR_EARLY_0,
  input  logic       EYE_MONITOR_LATE_0,
  input  logic       DELAY_LINE_OUT_OF_RANGE_0,
  output logic       DELAY_LINE_LOAD_0,
  output logic       DELAY_LINE_MOVE_0,
  output logic       DELAY_LINE_DIRECTION_0,
  output logic       EYE_MONITOR_CLEAR_FLAGS_0,
  output logic       BUSY,
  output logic       DONE,
  output logic       FAIL,
  output logic [7:0] TAP_CNT,
  output logic [7:0] LEFT_EDGE,
  output logic [7:0] RIGHT_EDGE
);

  typedef enum logic [3:0] {
    IDLE, LOAD, SETTLE, CLEAR, SAMPLE, EVAL, STEP, CENTER, DONE_S, FAIL_S
  } state_t;

  localparam logic [7:0] TAP_LAST    = 8'(TAP_MAX);
  localparam logic [7:0] SETTLE_LAST = 8'(SETTLE_CYCLES - 1);
  localparam logic [7:0] SAMPLE_LAST = 8'(SAMPLE_CYCLES - 1);

  state_t     state, state_nxt;
  logic [7:0] cnt;
  logic       err;
  logic       found_left;
  logic       centering;

  logic       idle_like;
  logic       settle_end;
  logic       sample_end;
  logic       sweep_end;
  logic       left_now;
  logic       right_hit;
  logic [8:0] edge_sum;
  logic [7:0] target;
  logic       at_target;

  assign idle_like  = (state == IDLE) || (state == DONE_S) || (state == FAIL_S);
  assign settle_end = (cnt == SETTLE_LAST);
  assign sample_end = (cnt == SAMPLE_LAST);
  assign sweep_end  = (TAP_CNT == TAP_LAST) || DELAY_LINE_OUT_OF_RANGE_0;
  // left edge counts as found if it was found earlier or this tap is clean
  assign left_now   = found_left || !err;
  assign right_hit  = err && found_left;
  assign edge_sum   = {1'b0, LEFT_EDGE} + {1'b0, RIGHT_EDGE};
  assign target     = edge_sum[8:1];
  assign at_target  = (TAP_CNT == target);

  // state register
  always_ff @(posedge FAB_CLK) begin
    if (SYNC_RST) state <= IDLE;
    else          state <= state_nxt;
  end

  // next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE, DONE_S, FAIL_S: if (START) state_nxt = LOAD;
      LOAD:                 state_nxt = SETTLE;
      SETTLE:               if (settle_end) state_nxt = centering ? CENTER : CLEAR;
      CLEAR:                state_nxt = SAMPLE;
      SAMPLE:               if (sample_end) state_nxt = EVAL;
      EVAL: begin
        if (right_hit)      state_nxt = CENTER;
        else if (sweep_end) state_nxt = left_now ? CENTER : FAIL_S;
        else                state_nxt = STEP;
      end
      STEP:                 state_nxt = SETTLE;
      CENTER:               state_nxt = at_target ? DONE_S : SETTLE;
      default:              state_nxt = IDLE;
    endcase
  end

  // outputs
  always_comb begin
    DELAY_LINE_LOAD_0         = 1'b0;
    DELAY_LINE_MOVE_0         = 1'b0;
    DELAY_LINE_DIRECTION_0    = 1'b0;
    EYE_MONITOR_CLEAR_FLAGS_0 = 1'b0;
    BUSY                      = !idle_like;
    DONE                      = (state == DONE_S);
    FAIL                      = (state == FAIL_S);
    case (state)
      LOAD:   DELAY_LINE_LOAD_0 = 1'b1;
      CLEAR:  EYE_MONITOR_CLEAR_FLAGS_0 = 1'b1;
      STEP: begin
        DELAY_LINE_MOVE_0      = 1'b1;
        DELAY_LINE_DIRECTION_0 = 1'b1;
      end
      CENTER: DELAY_LINE_MOVE_0 = !at_target;
      default: ;
    endcase
  end

  // datapath: tap tracking, window edges, cycle counter, error accumulator
  always_ff @(posedge FAB_CLK) begin
    if (SYNC_RST) begin
      cnt        <= '0;
      err        <= 1'b0;
      found_left <= 1'b0;
      centering  <= 1'b0;
      TAP_CNT    <= '0;
      LEFT_EDGE  <= '0;
      RIGHT_EDGE <= '0;
    end else begin
      if ((state == SETTLE && !settle_end) || (state == SAMPLE && !sample_end))
        cnt <= cnt + 8'd1;
      else
        cnt <= '0;

      case (state)
        IDLE, DONE_S, FAIL_S: begin
          if (START) begin
            LEFT_EDGE  <= '0;
            RIGHT_EDGE <= '0;
            found_left <= 1'b0;
            centering  <= 1'b0;
          end
        end
        LOAD: begin
          TAP_CNT   <= '0;
          centering <= 1'b0;
        end
        CLEAR:  err <= 1'b0;
        SAMPLE: err <= err | EYE_MONITOR_EARLY_0 | EYE_MONITOR_LATE_0;
        EVAL: begin
          if (!err && !found_left) begin
            LEFT_EDGE  <= TAP_CNT;
            found_left <= 1'b1;
          end
          // a failing tap after the window closes it one tap earlier
          if (right_hit) begin
            RIGHT_EDGE <= TAP_CNT - 8'd1;
            centering  <= 1'b1;
          end else if (sweep_end && left_now) begin
            RIGHT_EDGE <= TAP_CNT;
            centering  <= 1'b1;
          end
        end
        STEP:   if (TAP_CNT != TAP_LAST) TAP_CNT <= TAP_CNT + 8'd1;
        CENTER: if (!at_target && TAP_CNT != 8'd0) TAP_CNT <= TAP_CNT - 8'd1;
        default: ;
      endcase
    end
  end

endmodule
